// File: rtl/bitalign_lane_seq.sv
// bitalign_lane_seq: trains the bit_align lanes of a serdes receive bus one
// at a time (lane 0 upwards). Each attempt resets the lane, pulses its
// request, then waits for a fresh done edge, with a bounded wait and a fixed
// number of retries. Reports per-lane failures and a sticky pass-complete
// flag to the link bring-up logic.
module bitalign_lane_seq #(
  parameter int C_LANES   = 4,
  parameter int C_RST_CYC = 4,
  parameter int C_REQ_CYC = 2,
  parameter int C_TIMEOUT = 65536,
  parameter int C_RETRY   = 2,
  localparam int LW = (C_LANES > 1) ? $clog2(C_LANES) : 1
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic               START_I,
  output logic [C_LANES-1:0] LANE_RST_O,
  output logic [C_LANES-1:0] LANE_REQ_O,
  input  logic [C_LANES-1:0] LANE_DONE_I,
  output logic               BUSY_O,
  output logic [LW-1:0]      CUR_LANE_O,
  output logic               ALL_DONE_O,
  output logic               FAIL_O,
  output logic [C_LANES-1:0] FAIL_MASK_O
);

  localparam int CMAX = (C_RST_CYC > C_REQ_CYC) ? C_RST_CYC : C_REQ_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(C_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LRST,
    S_LREQ,
    S_WAIT,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t             state, state_nx;
  logic [LW-1:0]      lane, lane_nx;
  logic [3:0]         retry, retry_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [TW-1:0]      timer, timer_nx;
  logic [C_LANES-1:0] mask, mask_nx;
  logic [C_LANES-1:0] rst_nx, req_nx;
  logic               busy_nx, all_done_nx, fail_nx;
  logic               start_d;
  logic [C_LANES-1:0] done_d;
  logic               start_pos, done_rise;

  // One-hot select of a lane index; indices past the last lane select nothing.
  function automatic logic [C_LANES-1:0] lane_sel(input logic [LW-1:0] idx);
    lane_sel = '0;
    for (int i = 0; i < C_LANES; i++) begin
      if (LW'(i) == idx) lane_sel[i] = 1'b1;
    end
  endfunction

  assign start_pos = START_I & ~start_d;
  assign done_rise = LANE_DONE_I[lane] & ~done_d[lane];

  assign CUR_LANE_O  = lane;
  assign FAIL_MASK_O = mask;

  // Next-state and next-output decode; lane vectors are derived from the
  // state being entered so they stay registered and strictly one-hot.
  always_comb begin
    state_nx    = state;
    lane_nx     = lane;
    retry_nx    = retry;
    cnt_nx      = cnt;
    timer_nx    = timer;
    mask_nx     = mask;
    busy_nx     = BUSY_O;
    all_done_nx = ALL_DONE_O;
    fail_nx     = FAIL_O;
    case (state)
      S_IDLE: begin
        if (start_pos) begin
          lane_nx     = '0;
          retry_nx    = '0;
          cnt_nx      = '0;
          mask_nx     = '0;
          fail_nx     = 1'b0;
          all_done_nx = 1'b0;
          busy_nx     = 1'b1;
          state_nx    = S_LRST;
        end
      end
      S_LRST: begin
        if (cnt == CW'(C_RST_CYC - 1)) begin
          cnt_nx   = '0;
          state_nx = S_LREQ;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_LREQ: begin
        if (cnt == CW'(C_REQ_CYC - 1)) begin
          cnt_nx   = '0;
          timer_nx = '0;
          state_nx = S_WAIT;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (done_rise) begin
          state_nx = S_NEXT;
        end else if (timer == TW'(C_TIMEOUT - 1)) begin
          if (retry < 4'(C_RETRY)) begin
            retry_nx = retry + 4'd1;
            cnt_nx   = '0;
            state_nx = S_LRST;
          end else begin
            mask_nx[lane] = 1'b1;
            state_nx      = S_NEXT;
          end
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      S_NEXT: begin
        if (lane == LW'(C_LANES - 1)) begin
          state_nx = S_FINISH;
        end else begin
          lane_nx  = lane + 1'b1;
          retry_nx = '0;
          cnt_nx   = '0;
          state_nx = S_LRST;
        end
      end
      S_FINISH: begin
        all_done_nx = 1'b1;
        fail_nx     = |mask;
        busy_nx     = 1'b0;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    rst_nx = (state_nx == S_LRST) ? lane_sel(lane_nx) : '0;
    req_nx = (state_nx == S_LREQ) ? lane_sel(lane_nx) : '0;
  end

  // State, counters, edge-detect history and all outputs, cleared by reset.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state       <= S_IDLE;
      lane        <= '0;
      retry       <= '0;
      cnt         <= '0;
      timer       <= '0;
      mask        <= '0;
      start_d     <= 1'b0;
      done_d      <= '0;
      LANE_RST_O  <= '0;
      LANE_REQ_O  <= '0;
      BUSY_O      <= 1'b0;
      ALL_DONE_O  <= 1'b0;
      FAIL_O      <= 1'b0;
    end else begin
      state       <= state_nx;
      lane        <= lane_nx;
      retry       <= retry_nx;
      cnt         <= cnt_nx;
      timer       <= timer_nx;
      mask        <= mask_nx;
      start_d     <= START_I;
      done_d      <= LANE_DONE_I;
      LANE_RST_O  <= rst_nx;
      LANE_REQ_O  <= req_nx;
      BUSY_O      <= busy_nx;
      ALL_DONE_O  <= all_done_nx;
      FAIL_O      <= fail_nx;
    end
  end

endmodule

// File: doc/bitalign_lane_seq.md
Name: bitalign_lane_seq

Overview:
Multi-lane sequencer for the per-lane bit_align instances on a serdes receive bus. Trains the lanes one at a time, in order 0..C_LANES-1. For each lane it resets the lane's bit_align, pulses that lane's request, then waits for the done rising edge, with a timeout and retries. Reports per-lane pass/fail and a global done flag to the link bring-up logic. Sits in the same CLK_I domain as the IDELAY controllers.

Parameters:
C_LANES, 4, number of lanes sequenced (1..16)
C_RST_CYC, 4, cycles LANE_RST_O is held per attempt (>=1)
C_REQ_CYC, 2, cycles LANE_REQ_O is held per attempt (>=1)
C_TIMEOUT, 65536, WAIT cycles before an attempt is declared failed (>=2)
C_RETRY, 2, extra attempts after the first timeout (0..15)
LW (localparam), max(1,$clog2(C_LANES)), lane index width

Ports:
CLK_I  in  1  IDELAY control clock
RST_I  in  1  synchronous, active-high reset
START_I  in  1  rising edge starts a full training pass
LANE_RST_O  out  C_LANES  one-hot reset to the selected lane's bit_align RST_I
LANE_REQ_O  out  C_LANES  one-hot request to the selected lane's bit_align REQ_I
LANE_DONE_I  in  C_LANES  BITALIGN_DONE_O of each lane (level, sticky until lane reset)
BUSY_O  out  1  high from start acceptance until FINISH completes
CUR_LANE_O  out  LW  index of the lane currently being trained
ALL_DONE_O  out  1  pass complete; level, held until next accepted start
FAIL_O  out  1  OR of FAIL_MASK_O, valid while ALL_DONE_O=1
FAIL_MASK_O  out  C_LANES  bit i=1: lane i exhausted all attempts

Behaviour:
- All outputs are registered. Reset value of every output is 0. RST_I in any state forces IDLE and clears lane, retry, timer, mask, done_d and start_d.
- start_pos = START_I & ~start_d, where start_d is registered every cycle. start_pos is evaluated only in IDLE; edges in any other state are dropped, with no queueing.
- done_d[C_LANES-1:0] is registered every cycle. done_rise = LANE_DONE_I[lane] & ~done_d[lane]. Other lanes' inputs are ignored.
- IDLE: BUSY_O=0. On start_pos: lane<=0, retry<=0, FAIL_MASK_O<=0, FAIL_O<=0, ALL_DONE_O<=0, BUSY_O<=1, go to LRST.
- LRST: LANE_RST_O[lane]=1 for exactly C_RST_CYC cycles, then go to LREQ.
- LREQ: LANE_RST_O=0 and LANE_REQ_O[lane]=1 for exactly C_REQ_CYC cycles. Then go to WAIT with timer<=0.
- WAIT: both lane vectors are 0 and timer increments each cycle.
  - done_rise: the lane passes; go to NEXT.
  - Otherwise, when timer==C_TIMEOUT-1:
    - if retry<C_RETRY: retry<=retry+1 and go to LRST;
    - otherwise set FAIL_MASK_O[lane] and go to NEXT.
  - If done_rise and timeout occur in the same cycle, done wins and the lane passes.
  - A done edge outside WAIT is ignored.
- NEXT (1 cycle): if lane==C_LANES-1, go to FINISH. Otherwise lane<=lane+1, retry<=0, go to LRST.
- FINISH (1 cycle): ALL_DONE_O<=1, FAIL_O<=|FAIL_MASK_O, BUSY_O<=0, go to IDLE.
- CUR_LANE_O = lane at all times; it is 0 after reset and holds the last lane after FINISH.
- Timing: START_I rises before edge k (start_pos in IDLE at k). LANE_RST_O[0] is high in cycles k+1..k+C_RST_CYC. LANE_REQ_O[0] follows for C_REQ_CYC cycles. WAIT begins at k+1+C_RST_CYC+C_REQ_CYC.
- Per attempt: LRST+LREQ+WAIT = C_RST_CYC+C_REQ_CYC+(cycles to done). A timed-out attempt spends exactly C_TIMEOUT cycles in WAIT.
- Width rules:
  - timer width is $clog2(C_TIMEOUT) and must never wrap past C_TIMEOUT-1.
  - The rst/req counter width is $clog2(max(C_RST_CYC,C_REQ_CYC)+1).
  - retry is 4 bits.
- Lane vectors are strictly one-hot or zero. LANE_RST_O and LANE_REQ_O are never high in the same cycle.
- A second START while ALL_DONE_O=1 is accepted. It clears ALL_DONE_O, FAIL_O and the mask in the acceptance cycle.

Test Plan:
1. C_LANES=4, C_RST_CYC=4, C_REQ_CYC=2, each lane model asserts done 40 cycles after its req falls -> lanes trained in order 0..3, each RST 4 cycles then REQ 2 cycles, ALL_DONE_O=1, FAIL_MASK_O=4'b0000, FAIL_O=0, BUSY_O falls the same cycle ALL_DONE_O rises.
2. C_TIMEOUT=100, C_RETRY=1, lane 2 never asserts done -> lane 2 gets 2 attempts (2 RST pulses, 2 REQ pulses), each spending 100 WAIT cycles; lane 3 is still trained; FAIL_MASK_O=4'b0100, FAIL_O=1.
3. Lane 1 stuck at done=1 before start (sticky from a previous pass) -> no false pass; LANE_RST_O drops done, a fresh rise after REQ passes the lane; mask bit 1=0.
4. Lane 0 done rises exactly in the cycle where timer==C_TIMEOUT-1 -> lane passes, no retry, mask bit 0=0.
5. START_I toggled while BUSY_O=1, and LANE_DONE_I[3] pulsed while lane 1 is in WAIT -> both ignored; the sequence is unchanged, with only one pass.
6. RST_I asserted for 1 cycle mid-WAIT on lane 2 -> the next cycle has all outputs 0 and the state is IDLE; a subsequent START restarts from lane 0 with an empty mask.
